// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter from N CPU masters onto one synchronous RAM port
// and one IO window, with a debug master that overrides the whole bus.
module mem_bus_arbiter #(
  parameter int N_MASTER       = 2,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_MASTER-1:0]       m_req,
  input  logic [N_MASTER-1:0]       m_wr,
  input  logic [32*N_MASTER-1:0]    m_a,
  input  logic [8*N_MASTER-1:0]     m_dout,
  output logic [N_MASTER-1:0]       m_gnt,
  output logic [N_MASTER-1:0]       m_rvalid,
  output logic [7:0]                m_din,
  input  logic                      dbg_active,
  input  logic [RAM_ADDR_WIDTH-1:0] dbg_a,
  input  logic                      dbg_wr,
  input  logic [7:0]                dbg_dout,
  output logic [7:0]                dbg_din,
  output logic                      ram_en,
  output logic                      ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_din,
  input  logic [7:0]                ram_dout,
  output logic                      io_en,
  output logic [2:0]                io_sel,
  output logic                      io_wr,
  output logic [7:0]                io_din,
  input  logic [7:0]                io_dout,
  input  logic                      io_full
);

  localparam int PW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_MASTER - 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] rd_idx_q, rd_idx_d;
  logic          rd_io_q, rd_io_d;
  logic          rd_vld_q, rd_vld_d;

  logic [N_MASTER-1:0] io_win;
  logic [N_MASTER-1:0] elig;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       idx;
  logic                found;
  logic                gnt;
  logic                sel_io;
  logic                sel_wr;
  logic [RAM_ADDR_WIDTH-1:0] sel_a;
  logic [7:0]          sel_d;
  logic                unused_m_a;

  assign unused_m_a = ^m_a;

  // A full IO FIFO only blocks IO writes; others stay grantable.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      io_win[i] = m_a[32*i+RAM_ADDR_WIDTH -: 2] == 2'b11;
      elig[i]   = m_req[i] & ~(io_win[i] & m_wr[i] & io_full);
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (int'(rr_ptr_q) + k < N_MASTER)
        idx = rr_ptr_q + PW'(k);
      else
        idx = rr_ptr_q + PW'(k) - PW'(N_MASTER);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_io = 1'b0;
    sel_wr = 1'b0;
    sel_a  = '0;
    sel_d  = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (sel == PW'(i)) begin
        sel_io = io_win[i];
        sel_wr = m_wr[i];
        sel_a  = m_a[32*i +: RAM_ADDR_WIDTH];
        sel_d  = m_dout[8*i +: 8];
      end
    end
  end

  assign gnt = found & ~dbg_active & ~rst_in;

  always_comb begin
    for (int i = 0; i < N_MASTER; i++)
      m_gnt[i] = gnt && (sel == PW'(i));
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_r_nw = 1'b1;
    ram_a    = '0;
    ram_din  = '0;
    io_en    = 1'b0;
    io_sel   = '0;
    io_wr    = 1'b0;
    io_din   = '0;
    if (!rst_in && dbg_active) begin
      ram_en   = 1'b1;
      ram_r_nw = ~dbg_wr;
      ram_a    = dbg_a;
      ram_din  = dbg_dout;
    end else if (gnt && sel_io) begin
      io_en  = 1'b1;
      io_sel = sel_a[2:0];
      io_wr  = sel_wr;
      io_din = sel_d;
    end else if (gnt) begin
      ram_en   = 1'b1;
      ram_r_nw = ~sel_wr;
      ram_a    = sel_a;
      ram_din  = sel_d;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rd_idx_d = rd_idx_q;
    rd_io_d  = rd_io_q;
    rd_vld_d = gnt & ~sel_wr;
    if (gnt)
      rr_ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
    if (gnt && !sel_wr) begin
      rd_idx_d = sel;
      rd_io_d  = sel_io;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q <= '0;
      rd_idx_q <= '0;
      rd_io_q  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_idx_q <= rd_idx_d;
      rd_io_q  <= rd_io_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Only the source select is registered; read data passes straight through.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++)
      m_rvalid[i] = rd_vld_q && (rd_idx_q == PW'(i));
  end

  assign m_din   = rd_io_q ? io_dout : ram_dout;
  assign dbg_din = ram_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table plus read-data scoreboard,
// reset and 4-master wrap sequences.
module tb_mem_bus_arbiter;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in;
  logic [1:0]  m_req, m_wr, m_gnt, m_rvalid;
  logic [63:0] m_a;
  logic [15:0] m_dout;
  logic [7:0]  m_din;
  logic        dbg_active, dbg_wr;
  logic [16:0] dbg_a;
  logic [7:0]  dbg_dout, dbg_din;
  logic        ram_en, ram_r_nw;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;
  logic        io_en, io_wr, io_full;
  logic [2:0]  io_sel;
  logic [7:0]  io_din, io_dout;

  logic [3:0]   m_req4, m_wr4, m_gnt4, m_rvalid4;
  logic [127:0] m_a4;
  logic [31:0]  m_dout4;
  logic [7:0]   m_din4, dbg_din4, ram_din4, io_din4, ram_dout4;
  logic         dbg_active4, ram_en4, ram_r_nw4, io_en4, io_wr4, io_full4;
  logic [16:0]  ram_a4;
  logic [2:0]   io_sel4;

  mem_bus_arbiter u2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .m_req(m_req), .m_wr(m_wr), .m_a(m_a), .m_dout(m_dout),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_din(m_din),
    .dbg_active(dbg_active), .dbg_a(dbg_a), .dbg_wr(dbg_wr),
    .dbg_dout(dbg_dout), .dbg_din(dbg_din),
    .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr), .io_din(io_din),
    .io_dout(io_dout), .io_full(io_full)
  );

  mem_bus_arbiter #(.N_MASTER(4)) u4 (
    .clk_in(clk_in), .rst_in(rst_in),
    .m_req(m_req4), .m_wr(m_wr4), .m_a(m_a4), .m_dout(m_dout4),
    .m_gnt(m_gnt4), .m_rvalid(m_rvalid4), .m_din(m_din4),
    .dbg_active(dbg_active4), .dbg_a(dbg_a), .dbg_wr(dbg_wr),
    .dbg_dout(dbg_dout), .dbg_din(dbg_din4),
    .ram_en(ram_en4), .ram_r_nw(ram_r_nw4), .ram_a(ram_a4),
    .ram_din(ram_din4), .ram_dout(ram_dout4),
    .io_en(io_en4), .io_sel(io_sel4), .io_wr(io_wr4), .io_din(io_din4),
    .io_dout(io_dout), .io_full(io_full4)
  );

  wire unused_tb = ^{m_rvalid4, m_din4, dbg_din4, ram_r_nw4, ram_a4,
                     ram_din4, io_sel4, io_wr4, io_din4, io_en4};

  // Synchronous RAM model with a few preloaded bytes.
  logic [7:0] mem   [0:131071];
  logic       wflag [0:131071];

  function automatic logic [7:0] init_byte(input logic [16:0] a);
    case (a)
      17'h10:  return 8'h11;
      17'h20:  return 8'h22;
      17'h40:  return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (ram_en) begin
      if (!ram_r_nw) begin
        mem[ram_a]   <= ram_din;
        wflag[ram_a] <= 1'b1;
      end else begin
        ram_dout <= wflag[ram_a] ? mem[ram_a] : init_byte(ram_a);
      end
    end
  end

  typedef struct {
    logic [1:0]  req, wr;
    logic [31:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        full, dbg, dwr;
    logic [16:0] da;
    logic [7:0]  dd;
    logic [1:0]  e_gnt;
    logic        e_ram, e_rnw, e_io, e_iowr;
    logic [16:0] e_ra;
    logic [2:0]  e_sel;
    logic [7:0]  e_din, e_rd;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] rv;
    logic [7:0] d;
  } sb_t;

  vec_t tv [17];
  vec_t v_a, v_c, v_idle;
  sb_t  sb [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("rvalid", 32'(m_rvalid), 32'(e.rv));
      chk("rdata", 32'(m_din), 32'(e.d));
    end else begin
      chk("rvalid_idle", 32'(m_rvalid), 32'd0);
    end
  endtask

  task automatic step(input vec_t v);
    m_req      = v.req;
    m_wr       = v.wr;
    m_a        = {v.a1, v.a0};
    m_dout     = {v.d1, v.d0};
    io_full    = v.full;
    dbg_active = v.dbg;
    dbg_wr     = v.dwr;
    dbg_a      = v.da;
    dbg_dout   = v.dd;
    #4;
    sb_check();
    chk("gnt", 32'(m_gnt), 32'(v.e_gnt));
    chk("ram_en", 32'(ram_en), 32'(v.e_ram));
    chk("io_en", 32'(io_en), 32'(v.e_io));
    chk("io_wr", 32'(io_wr), 32'(v.e_iowr));
    if (v.e_ram) begin
      chk("ram_a", 32'(ram_a), 32'(v.e_ra));
      chk("ram_r_nw", 32'(ram_r_nw), 32'(v.e_rnw));
      if (!v.e_rnw)
        chk("ram_din", 32'(ram_din), 32'(v.e_din));
    end
    if (v.e_io) begin
      chk("io_sel", 32'(io_sel), 32'(v.e_sel));
      if (v.e_iowr)
        chk("io_din", 32'(io_din), 32'(v.e_din));
    end
    if (v.e_gnt != 2'b00 && (v.e_gnt & v.wr) == 2'b00)
      sb.push_back('{cyc + 1, v.e_gnt, v.e_rd});
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic step4(input logic [3:0] req, input logic [3:0] eg);
    m_req4 = req;
    #4;
    chk("gnt4", 32'(m_gnt4), 32'(eg));
    chk("ram_en4", 32'(ram_en4), 32'(|eg));
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    m_req = 2'b11; m_wr = 2'b00;
    m_a = {32'h20, 32'h10}; m_dout = '0;
    dbg_active = 1'b0; dbg_wr = 1'b0;
    dbg_a = '0; dbg_dout = '0;
    io_dout = 8'h5A; io_full = 1'b0;
    m_req4 = '0; m_wr4 = 4'hF; m_a4 = '0; m_dout4 = '0;
    dbg_active4 = 1'b0; ram_dout4 = 8'h00; io_full4 = 1'b0;

    // req, wr, a0, a1, d0, d1, full, dbg, dwr, da, dd |
    // gnt, ram, rnw, io, iowr, ra, sel, din, rd
    tv[0]  = '{2'b11, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h10, 3'd0, 8'h00, 8'h11};
    tv[1]  = '{2'b11, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 17'h20, 3'd0, 8'h00, 8'h22};
    tv[2]  = tv[0];
    tv[3]  = tv[1];
    tv[4]  = '{2'b11, 2'b01, 32'h30000, 32'h40, 8'h41, 8'h00, 1'b1, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 17'h40, 3'd0, 8'h00, 8'h77};
    tv[5]  = '{2'b01, 2'b01, 32'h30000, 32'h40, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 17'h0, 3'd0, 8'h41, 8'h00};
    tv[6]  = '{2'b10, 2'b00, 32'h0, 32'h30004, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 17'h0, 3'd4, 8'h00, 8'h5A};
    tv[7]  = '{2'b01, 2'b00, 32'h40, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h40, 3'd0, 8'h00, 8'h77};
    tv[8]  = '{2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0, 3'd0, 8'h00, 8'h00};
    tv[9]  = '{2'b11, 2'b11, 32'h80, 32'h90, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 17'h90, 3'd0, 8'h66, 8'h00};
    tv[10] = '{2'b01, 2'b01, 32'h80, 32'h90, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 17'h80, 3'd0, 8'h55, 8'h00};
    tv[11] = '{2'b11, 2'b00, 32'h80, 32'h90, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 17'h90, 3'd0, 8'h00, 8'h66};
    tv[12] = '{2'b01, 2'b01, 32'h30003, 32'h0, 8'h41, 8'h00, 1'b1, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0, 3'd0, 8'h00, 8'h00};
    tv[13] = '{2'b01, 2'b00, 32'h80, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h80, 3'd0, 8'h00, 8'h55};
    tv[14] = '{2'b11, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 17'h100, 8'hA5,
               2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 17'h100, 3'd0, 8'hA5, 8'h00};
    tv[15] = '{2'b11, 2'b00, 32'h100, 32'h100, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 17'h100, 3'd0, 8'h00, 8'hA5};
    tv[16] = tv[8];
    v_idle = tv[8];
    v_a    = '{2'b01, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h10, 3'd0, 8'h00, 8'h11};
    v_c    = '{2'b11, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00,
               2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 17'h10, 3'd0, 8'h00, 8'h11};

    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_io_en", 32'(io_en), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_m_din", 32'(m_din), 32'h00);
    rst_in = 1'b0;

    for (int i = 0; i < 17; i++)
      step(tv[i]);

    // Asynchronous reset while a read is granted and another is returning.
    step(v_a);
    m_req = 2'b10;
    m_wr  = 2'b00;
    m_a   = {32'h20, 32'h10};
    #2;
    sb_check();
    chk("pre_rst_gnt", 32'(m_gnt), 32'(2'b10));
    #1;
    rst_in = 1'b1;
    #1;
    chk("in_rst_gnt", 32'(m_gnt), 32'd0);
    chk("in_rst_ram_en", 32'(ram_en), 32'd0);
    chk("in_rst_io_en", 32'(io_en), 32'd0);
    chk("in_rst_rvalid", 32'(m_rvalid), 32'd0);
    m_req = 2'b00;
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    cyc++;
    step(v_c);
    step(v_idle);

    // Four masters: 3 granted first, pointer wraps to 0, then moves to 1.
    step4(4'b1000, 4'b1000);
    step4(4'b1001, 4'b0001);
    step4(4'b1001, 4'b1000);
    step4(4'b0000, 4'b0000);

    chk("dbg_din", 32'(dbg_din), 32'h11);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 2: number of CPU-side bus masters (1..8).
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 17: RAM address width; IO window is a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all state on posedge.
REQ-004 SHALL have port rst_in, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port m_req, input, N_MASTER: per-master access request.
REQ-006 SHALL have port m_wr, input, N_MASTER: per-master write (1) / read (0).
REQ-007 SHALL have port m_a, input, 32*N_MASTER: per-master byte address; master i uses bits [32i+31:32i].
REQ-008 SHALL have port m_dout, input, 8*N_MASTER: per-master write data.
REQ-009 SHALL have port m_gnt, output, N_MASTER: one-hot or zero; access accepted this cycle.
REQ-010 SHALL have port m_rvalid, output, N_MASTER: read data valid for master i, one cycle after its read grant.
REQ-011 SHALL have port m_din, output, 8: shared read data, qualified by m_rvalid.
REQ-012 SHALL have port dbg_active, input, 1: debug master owns the bus.
REQ-013 SHALL have ports dbg_a, input, RAM_ADDR_WIDTH; dbg_wr, input, 1; dbg_dout, input, 8: debug access.
REQ-014 SHALL have port dbg_din, output, 8: equals ram_dout at all times.
REQ-015 SHALL have ports ram_en, output, 1; ram_r_nw, output, 1; ram_a, output, RAM_ADDR_WIDTH; ram_din, output, 8; ram_dout, input, 8: synchronous RAM, 1-cycle read latency.
REQ-016 SHALL have ports io_en, output, 1; io_sel, output, 3; io_wr, output, 1; io_din, output, 8; io_dout, input, 8; io_full, input, 1: IO block.

Function
REQ-017 SHALL keep a round-robin pointer rr_ptr (0..N_MASTER-1); selected master = first i with m_req[i] and eligible, searching rr_ptr, rr_ptr+1, ... mod N_MASTER.
REQ-018 SHALL treat a master as ineligible when its request is an IO-window write and io_full=1; other masters remain grantable that cycle.
REQ-019 SHALL assert m_gnt[sel] combinationally in the same cycle as the selected request; at most one bit set.
REQ-020 SHALL, on a grant, load rr_ptr <= (sel+1) mod N_MASTER at the next posedge; with no grant, rr_ptr unchanged.
REQ-021 SHALL drive, for a granted RAM-window access: ram_en=1, ram_r_nw=~m_wr[sel], ram_a=m_a[sel][RAM_ADDR_WIDTH-1:0], ram_din=m_dout[sel], io_en=0.
REQ-022 SHALL drive, for a granted IO-window access: io_en=1, io_sel=m_a[sel][2:0], io_wr=m_wr[sel], io_din=m_dout[sel], ram_en=0.
REQ-023 SHALL hold ram_en=0, io_en=0, io_wr=0 when no grant and dbg_active=0.
REQ-024 SHALL register, per granted read: q_rd_idx<=sel, q_rd_io<=(IO window), m_rvalid[q_rd_idx] asserted exactly one cycle later for one cycle.
REQ-025 SHALL drive m_din = q_rd_io ? io_dout : ram_dout (select registered, data not).
REQ-026 SHALL, while dbg_active=1: force m_gnt=0, drive ram_en=1, ram_r_nw=~dbg_wr, ram_a=dbg_a, ram_din=dbg_dout, io_en=0, freeze rr_ptr.
REQ-027 SHALL still deliver m_rvalid for a read granted in the cycle before dbg_active rises.
REQ-028 SHALL accept back-to-back grants every cycle (throughput 1 access/cycle).
REQ-029 SHALL wrap rr_ptr from N_MASTER-1 to 0; N_MASTER=1 degenerates to fixed grant.

Reset
REQ-030 SHALL, while rst_in=1, force rr_ptr=0, q_rd_io=0, q_rd_idx=0, m_rvalid=0, hence m_din=ram_dout.
REQ-031 SHALL suppress m_gnt, ram_en and io_en while rst_in=1; an in-flight read is discarded (no m_rvalid after reset release).

Verification
REQ-032 SHALL cover: N=2, both m_req=1 reads to RAM 0x00010/0x00020 for 4 cycles -> grants alternate 0,1,0,1; m_rvalid[i] one cycle after each grant with stored bytes.
REQ-033 SHALL cover: master 0 write 0x41 to 0x30000 with io_full=1, master 1 RAM read -> master 1 granted, master 0 waits; io_full->0 -> master 0 granted, io_en=1, io_sel=0, io_din=0x41.
REQ-034 SHALL cover: master 1 reads 0x30004 (io_dout=0x5A) then master 0 reads RAM (0x77) next cycle -> m_din=0x5A with m_rvalid[1], then 0x77 with m_rvalid[0].
REQ-035 SHALL cover: dbg_active=1 with both masters requesting, dbg writes 0xA5 to 0x00100 -> m_gnt=0, RAM written; after release, master read of 0x00100 returns 0xA5, rr_ptr unchanged.
REQ-036 SHALL cover: rst_in pulsed mid-cycle (asynchronous) during a granted read -> m_rvalid stays 0, rr_ptr=0, first post-reset grant goes to master 0.
REQ-037 SHALL cover: N_MASTER=4, only master 3 then master 0 requesting -> grant 3 then 0 (wrap), rr_ptr sequence 0->0 (3 granted sets 0)->1.
